hdmi_timing_gen: RTL and testbench

HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

---
 rtl/hdmi_timing_gen.sv | 139 +++++++++++++
 tb/tb_hdmi_timing_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_timing_gen.sv
// Video timing generator: free-running h/v counters with registered sync, data enable,
// pixel coordinates and a selectable test pattern (colour bars, grey ramp, grid, solid).
module hdmi_timing_gen #(
  parameter logic [11:0] H_TOTAL = 12'd2200,
  parameter logic [11:0] H_SYNC  = 12'd44,
  parameter logic [11:0] H_BP    = 12'd148,
  parameter logic [11:0] H_ACT   = 12'd1920,
  parameter logic [11:0] V_TOTAL = 12'd1125,
  parameter logic [11:0] V_SYNC  = 12'd5,
  parameter logic [11:0] V_BP    = 12'd36,
  parameter logic [11:0] V_ACT   = 12'd1080
) (
  input  logic        pix_clk,
  input  logic        rst,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic [11:0] x_out,
  output logic [11:0] y_out,
  output logic        frame_start
);

  localparam logic [11:0] HA0 = H_SYNC + H_BP;
  localparam logic [11:0] HA1 = HA0 + H_ACT;
  localparam logic [11:0] VA0 = V_SYNC + V_BP;
  localparam logic [11:0] VA1 = VA0 + V_ACT;
  // Bar edges are precomputed constants so bar selection needs only comparators.
  localparam logic [11:0] BW  = H_ACT >> 3;
  localparam logic [11:0] B2  = BW * 12'd2;
  localparam logic [11:0] B3  = BW * 12'd3;
  localparam logic [11:0] B4  = BW * 12'd4;
  localparam logic [11:0] B5  = BW * 12'd5;
  localparam logic [11:0] B6  = BW * 12'd6;
  localparam logic [11:0] B7  = BW * 12'd7;

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;
  logic [1:0]  mode_lat;
  logic        h_act;
  logic        v_act;
  logic        de;
  logic        h_last;
  logic        v_last;
  logic [11:0] x;
  logic [11:0] y;
  logic [23:0] rgb;

  assign h_act  = (h_cnt >= HA0) && (h_cnt < HA1);
  assign v_act  = (v_cnt >= VA0) && (v_cnt < VA1);
  assign de     = h_act && v_act;
  // >= keeps the counters bounded even if they were ever out of range.
  assign h_last = (h_cnt >= H_TOTAL - 12'd1);
  assign v_last = (v_cnt >= V_TOTAL - 12'd1);
  assign x      = de ? (h_cnt - HA0) : 12'd0;
  assign y      = de ? (v_cnt - VA0) : 12'd0;

  always_ff @(posedge pix_clk) begin
    if (rst) begin
      h_cnt    <= 12'd0;
      v_cnt    <= 12'd0;
      mode_lat <= 2'd0;
    end else if (!en) begin
      h_cnt    <= 12'd0;
      v_cnt    <= 12'd0;
    end else begin
      if ((h_cnt == 12'd0) && (v_cnt == 12'd0)) begin
        mode_lat <= mode;
      end
      if (h_last) begin
        h_cnt <= 12'd0;
        v_cnt <= v_last ? 12'd0 : (v_cnt + 12'd1);
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

  always_comb begin
    rgb = 24'h000000;
    if (de) begin
      case (mode_lat)
        2'd0: begin
          if (x < BW)      rgb = 24'hFFFFFF;
          else if (x < B2) rgb = 24'hFFFF00;
          else if (x < B3) rgb = 24'h00FFFF;
          else if (x < B4) rgb = 24'h00FF00;
          else if (x < B5) rgb = 24'hFF00FF;
          else if (x < B6) rgb = 24'hFF0000;
          else if (x < B7) rgb = 24'h0000FF;
          else             rgb = 24'h000000;
        end
        2'd1: rgb = {3{x[10:3]}};
        2'd2: begin
          if ((x[5:0] == 6'd0) || (y[5:0] == 6'd0) ||
              (x == H_ACT - 12'd1) || (y == V_ACT - 12'd1)) begin
            rgb = 24'hFFFFFF;
          end else begin
            rgb = 24'h000000;
          end
        end
        2'd3:    rgb = solid_rgb;
        default: rgb = 24'h000000;
      endcase
    end else begin
      rgb = 24'h000000;
    end
  end

  always_ff @(posedge pix_clk) begin
    if (rst || !en) begin
      vs_out      <= 1'b0;
      hs_out      <= 1'b0;
      de_out      <= 1'b0;
      r_out       <= 8'd0;
      g_out       <= 8'd0;
      b_out       <= 8'd0;
      x_out       <= 12'd0;
      y_out       <= 12'd0;
      frame_start <= 1'b0;
    end else begin
      vs_out      <= (v_cnt < V_SYNC);
      hs_out      <= (h_cnt < H_SYNC);
      de_out      <= de;
      r_out       <= rgb[23:16];
      g_out       <= rgb[15:8];
      b_out       <= rgb[7:0];
      x_out       <= x;
      y_out       <= y;
      frame_start <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end
  end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Bench for hdmi_timing_gen: frame-position reference model checked every cycle, a pixel
// table checked against captured frames, and hand-written enable/reset sequences.
module tb_hdmi_timing_gen;

  localparam int HT = 140, HS = 3, HBP = 5, HACT = 128;
  localparam int VT = 72, VS = 2, VBP = 3, VACT = 66;
  localparam int HA0 = HS + HBP, VA0 = VS + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [2:0] BAR [0:7] = '{3'd7, 3'd6, 3'd3, 3'd2, 3'd5, 3'd4, 3'd1, 3'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] solid = 24'd0;
  logic        vs_out, hs_out, de_out, frame_start;
  logic [7:0]  r_out, g_out, b_out;
  logic [11:0] x_out, y_out;

  int checks = 0;
  int failures = 0;
  int pos = 0;
  logic [1:0]  fmode = 2'd0;
  logic [51:0] exp_vec = '0;
  logic [51:0] out_vec;
  logic [23:0] pix [0:VACT-1][0:HACT-1];

  typedef struct {
    logic [1:0]  mode;
    int          x;
    int          y;
    logic [23:0] rgb;
  } vec_t;
  vec_t tbl [$];

  hdmi_timing_gen #(
    .H_TOTAL(12'd140), .H_SYNC(12'd3), .H_BP(12'd5), .H_ACT(12'd128),
    .V_TOTAL(12'd72), .V_SYNC(12'd2), .V_BP(12'd3), .V_ACT(12'd66)
  ) dut (
    .pix_clk(clk), .rst(rst), .en(en), .mode(mode), .solid_rgb(solid),
    .vs_out(vs_out), .hs_out(hs_out), .de_out(de_out),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .x_out(x_out), .y_out(y_out), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  assign out_vec = {vs_out, hs_out, de_out, frame_start, r_out, g_out, b_out, x_out, y_out};

  // Expected outputs for a position within the frame, from the raster rules directly.
  function automatic logic [51:0] calc(int p, logic [1:0] m, logic [23:0] s);
    int h, v;
    logic de;
    logic [11:0] xv, yv;
    logic [23:0] c;
    logic [2:0] b;
    h = p % HT;
    v = p / HT;
    de = (h >= HA0) && (h < HA0 + HACT) && (v >= VA0) && (v < VA0 + VACT);
    xv = de ? 12'(h - HA0) : 12'd0;
    yv = de ? 12'(v - VA0) : 12'd0;
    c = 24'd0;
    if (de) begin
      case (m)
        2'd0: begin
          b = BAR[int'(xv) / (HACT / 8)];
          c = {{8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        end
        2'd1: c = {3{xv[10:3]}};
        2'd2: c = ((int'(xv) % 64 == 0) || (int'(yv) % 64 == 0) ||
                   (int'(xv) == HACT - 1) || (int'(yv) == VACT - 1)) ? 24'hFFFFFF : 24'h0;
        default: c = s;
      endcase
    end
    return {v < VS, h < HS, de, p == 0, c, xv, yv};
  endfunction

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      if (failures <= 30) $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  // One clock: advance the reference model with the inputs in force, then compare.
  task automatic cyc();
    @(posedge clk);
    if (rst) begin
      exp_vec = '0; pos = 0; fmode = 2'd0;
    end else if (!en) begin
      exp_vec = '0; pos = 0;
    end else begin
      if (pos == 0) fmode = mode;
      exp_vec = calc(pos, fmode, solid);
      pos = (pos + 1) % FRAME;
    end
    #1;
    check("cycle", out_vec, exp_vec);
  endtask

  // Capture one full frame starting at its first output cycle; optionally change inputs mid-frame.
  task automatic capture_frame(int change_at, logic [1:0] next_mode, logic [23:0] next_solid);
    int de_n, vs_n, hs_n, fs_n, first_de, last_rise, per_err;
    logic prev_hs;
    de_n = 0; vs_n = 0; hs_n = 0; fs_n = 0; first_de = -1; last_rise = -1; per_err = 0;
    prev_hs = 1'b0;
    for (int k = 0; k < FRAME; k++) begin
      cyc();
      if (k == 0) check("frame_start_at_frame_begin", 64'(frame_start), 64'd1);
      if (de_out) begin
        de_n++;
        if (first_de < 0) begin
          first_de = k;
          check("first_active_xy", {x_out, y_out}, 64'd0);
          check("first_active_cycle", 64'(k), 64'(VA0 * HT + HA0));
        end
        if (k == FRAME - HT * (VT - VA0 - VACT) - (HT - HA0 - HACT) - 1)
          check("last_active_xy", {x_out, y_out}, {12'd127, 12'd65});
        if (x_out < HACT && y_out < VACT) pix[y_out][x_out] = {r_out, g_out, b_out};
      end
      if (vs_out) vs_n++;
      if (hs_out) hs_n++;
      if (frame_start) fs_n++;
      if (hs_out && !prev_hs) begin
        if (last_rise >= 0 && k - last_rise != HT) per_err++;
        last_rise = k;
      end
      prev_hs = hs_out;
      if (k == change_at) begin
        mode = next_mode;
        solid = next_solid;
      end
    end
    check("de_count", 64'(de_n), 64'(HACT * VACT));
    check("vs_count", 64'(vs_n), 64'(VS * HT));
    check("hs_count", 64'(hs_n), 64'(HS * VT));
    check("fs_count", 64'(fs_n), 64'd1);
    check("hs_period_errors", 64'(per_err), 64'd0);
  endtask

  task automatic check_table(logic [1:0] m);
    foreach (tbl[i]) begin
      if (tbl[i].mode == m) check($sformatf("pix_m%0d_x%0d_y%0d", m, tbl[i].x, tbl[i].y),
                                  64'(pix[tbl[i].y][tbl[i].x]), 64'(tbl[i].rgb));
    end
  endtask

  initial begin
    int cnt;
    int bad;
    tbl = '{
      '{2'd0, 0, 0, 24'hFFFFFF}, '{2'd0, 16, 3, 24'hFFFF00}, '{2'd0, 47, 10, 24'h00FFFF},
      '{2'd0, 48, 10, 24'h00FF00}, '{2'd0, 64, 20, 24'hFF00FF}, '{2'd0, 80, 30, 24'hFF0000},
      '{2'd0, 111, 65, 24'h0000FF}, '{2'd0, 112, 65, 24'h000000}, '{2'd0, 127, 0, 24'h000000},
      '{2'd1, 100, 7, 24'h0C0C0C}, '{2'd1, 0, 0, 24'h000000}, '{2'd1, 127, 40, 24'h0F0F0F},
      '{2'd2, 64, 5, 24'hFFFFFF}, '{2'd2, 65, 5, 24'h000000}, '{2'd2, 127, 5, 24'hFFFFFF},
      '{2'd2, 3, 65, 24'hFFFFFF}, '{2'd2, 3, 64, 24'hFFFFFF}, '{2'd2, 3, 63, 24'h000000},
      '{2'd2, 0, 30, 24'hFFFFFF},
      '{2'd3, 50, 50, 24'h123456}, '{2'd3, 0, 0, 24'h123456}, '{2'd3, 127, 65, 24'h123456}
    };

    // Reset and idle state.
    rst = 1'b1; en = 1'b1;
    repeat (3) cyc();
    check("reset_outputs", 64'(out_vec), 64'd0);
    rst = 1'b0; en = 1'b0;
    repeat (2) cyc();
    check("idle_outputs", 64'(out_vec), 64'd0);

    // Four captured frames; each mode change lands mid-frame and must wait for the next frame.
    en = 1'b1; mode = 2'd0;
    capture_frame(5000, 2'd1, 24'h0);
    check_table(2'd0);
    capture_frame(5000, 2'd2, 24'h0);
    check_table(2'd1);
    capture_frame(5000, 2'd3, 24'h123456);
    check_table(2'd2);
    capture_frame(-1, 2'd3, 24'h123456);
    check_table(2'd3);
    bad = 0;
    for (int yy = 0; yy < VACT; yy++)
      for (int xx = 0; xx < HACT; xx++)
        if (pix[yy][xx] !== 24'h123456) bad++;
    check("solid_frame_bad_pixels", 64'(bad), 64'd0);

    // Enable dropped mid-frame, then raised again.
    repeat (3000) begin solid = $urandom; cyc(); end
    en = 1'b0;
    cyc();
    check("en_off_outputs", 64'(out_vec), 64'd0);
    repeat (3) cyc();
    en = 1'b1;
    cyc();
    check("en_rise_fs_vs_hs", {frame_start, vs_out, hs_out}, 64'd7);

    // Reset at the 300th active pixel, then release.
    cnt = 0;
    for (int k = 0; k < 2 * FRAME && cnt < 300; k++) begin
      cyc();
      if (de_out) cnt++;
    end
    check("reached_300th_pixel", 64'(cnt), 64'd300);
    rst = 1'b1;
    repeat (3) begin
      cyc();
      check("outputs_in_reset", 64'(out_vec), 64'd0);
    end
    rst = 1'b0;
    cyc();
    check("fs_after_reset", 64'(frame_start), 64'd1);

    // Randomized run against the model.
    for (int k = 0; k < 15000; k++) begin
      solid = $urandom;
      if ($urandom_range(499, 0) == 0) mode = 2'($urandom);
      if (rst) rst = 1'b0;
      else if ($urandom_range(3999, 0) == 0) rst = 1'b1;
      if (en) begin
        if ($urandom_range(2999, 0) == 0) en = 1'b0;
      end else if ($urandom_range(19, 0) == 0) en = 1'b1;
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
